// File: rtl/alu_core_pkg.sv
// Shared types and constants for the alu_core datapath.
package alu_core_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int PC_INC       = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_core_adder64.sv
// Combinational W-bit adder; sub=1 computes a - b via inverted b and carry-in.
module adder64 #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum
);

  logic [W-1:0] b_eff;

  always_comb begin
    b_eff = b ^ {W{sub}};
    sum   = a + b_eff + {{(W-1){1'b0}}, sub};
  end

endmodule

// File: rtl/alu_core.sv
// Single-cycle registered ALU with PC increment and branch target generation.
// Optional macro ALU_OVF_FLAG_EN adds a registered signed-overflow flag `ovf`.
module alu_core
  import alu_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [2:0]      alu_sel,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_out,
  output logic            zero,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target
`ifdef ALU_OVF_FLAG_EN
  ,
  output logic            ovf
`endif
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e         op_s;
  logic            sub_s;
  logic [XLEN-1:0] addsub_s;
  logic [XLEN-1:0] pc_plus4_s;
  logic [XLEN-1:0] branch_target_s;
  logic [XLEN-1:0] imm_shl_s;
  logic            slt_s;
  logic [XLEN-1:0] result_s;

  logic            out_valid_d, out_valid_q;
  logic [XLEN-1:0] alu_out_d, alu_out_q;
  logic            zero_d, zero_q;
  logic [XLEN-1:0] pc_plus4_d, pc_plus4_q;
  logic [XLEN-1:0] branch_target_d, branch_target_q;

  assign op_s      = alu_op_e'(alu_sel);
  assign sub_s     = (op_s != ALU_ADD);
  assign imm_shl_s = imm << 1'b1;

  adder64 #(.W(XLEN)) u_addsub (
    .a   (a),
    .b   (b),
    .sub (sub_s),
    .sum (addsub_s)
  );

  adder64 #(.W(XLEN)) u_pc_inc (
    .a   (pc),
    .b   (XLEN'(PC_INC)),
    .sub (1'b0),
    .sum (pc_plus4_s)
  );

  adder64 #(.W(XLEN)) u_br_tgt (
    .a   (pc),
    .b   (imm_shl_s),
    .sub (1'b0),
    .sum (branch_target_s)
  );

  // Signed less-than: sign of a-b corrected by the subtraction overflow.
  assign slt_s = addsub_s[XLEN-1] ^
                 ((a[XLEN-1] != b[XLEN-1]) && (addsub_s[XLEN-1] != a[XLEN-1]));

  always_comb begin
    result_s = '0;
    case (op_s)
      ALU_ADD: result_s = addsub_s;
      ALU_SUB: result_s = addsub_s;
      ALU_AND: result_s = a & b;
      ALU_OR:  result_s = a | b;
      ALU_XOR: result_s = a ^ b;
      ALU_SLL: result_s = a << b[SHW-1:0];
      ALU_SRL: result_s = a >> b[SHW-1:0];
      ALU_SLT: result_s = {{(XLEN-1){1'b0}}, slt_s};
      default: result_s = '0;
    endcase
  end

  always_comb begin
    out_valid_d     = 1'b0;
    alu_out_d       = alu_out_q;
    zero_d          = zero_q;
    pc_plus4_d      = pc_plus4_q;
    branch_target_d = branch_target_q;
    if (in_valid) begin
      out_valid_d     = 1'b1;
      alu_out_d       = result_s;
      zero_d          = (result_s == '0);
      pc_plus4_d      = pc_plus4_s;
      branch_target_d = branch_target_s;
    end else begin
      out_valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q     <= 1'b0;
      alu_out_q       <= '0;
      zero_q          <= 1'b0;
      pc_plus4_q      <= '0;
      branch_target_q <= '0;
    end else begin
      out_valid_q     <= out_valid_d;
      alu_out_q       <= alu_out_d;
      zero_q          <= zero_d;
      pc_plus4_q      <= pc_plus4_d;
      branch_target_q <= branch_target_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_out       = alu_out_q;
  assign zero          = zero_q;
  assign pc_plus4      = pc_plus4_q;
  assign branch_target = branch_target_q;

`ifdef ALU_OVF_FLAG_EN
  logic ovf_s;
  logic ovf_d, ovf_q;

  // Overflow when both effective operands share a sign that the sum does not.
  assign ovf_s = ((op_s == ALU_ADD) || (op_s == ALU_SUB)) &&
                 (a[XLEN-1] == (b[XLEN-1] ^ sub_s)) &&
                 (addsub_s[XLEN-1] != a[XLEN-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) begin
      ovf_d = ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Randomized self-checking bench for alu_core against a behavioural model.
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  alu_sel;
  logic [63:0] a, b, pc, imm;
  logic        out_valid;
  logic [63:0] alu_out;
  logic        zero;
  logic [63:0] pc_plus4;
  logic [63:0] branch_target;
`ifdef ALU_OVF_FLAG_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] m_alu, m_pc4, m_bt;
  logic        m_zero, m_vld, m_ovf;

  alu_core #(.XLEN(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .alu_sel       (alu_sel),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .imm           (imm),
    .out_valid     (out_valid),
    .alu_out       (alu_out),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
`ifdef ALU_OVF_FLAG_EN
    ,
    .ovf           (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_alu(input logic [2:0] s, input logic [63:0] x, input logic [63:0] y);
    case (s)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return x << (y % 64);
      3'd6: return x >> (y % 64);
      default: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [2:0] s, input logic [63:0] x, input logic [63:0] y);
    logic signed [65:0] wide;
    if (s == 3'd0) wide = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
    else if (s == 3'd1) wide = $signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y});
    else return 1'b0;
    return (wide > 66'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -66'sh0_8000_0000_0000_0000);
  endfunction

  task automatic step(input logic r, input logic v, input logic [2:0] s,
                      input logic [63:0] ta, input logic [63:0] tb, input logic [63:0] tpc,
                      input logic [63:0] timm);
    rst = r; in_valid = v; alu_sel = s; a = ta; b = tb; pc = tpc; imm = timm;
    @(posedge clk);
    if (r) begin
      m_alu = 64'd0; m_zero = 1'b0; m_pc4 = 64'd0; m_bt = 64'd0; m_vld = 1'b0; m_ovf = 1'b0;
    end else if (v) begin
      m_alu  = ref_alu(s, ta, tb);
      m_zero = (m_alu == 64'd0);
      m_pc4  = tpc + 64'd4;
      m_bt   = tpc + timm * 64'd2;
      m_vld  = 1'b1;
      m_ovf  = ref_ovf(s, ta, tb);
    end else begin
      m_vld = 1'b0;
    end
    #1;
    check("out_valid", {63'd0, out_valid}, {63'd0, m_vld});
    check("alu_out", alu_out, m_alu);
    check("zero", {63'd0, zero}, {63'd0, m_zero});
    check("pc_plus4", pc_plus4, m_pc4);
    check("branch_target", branch_target, m_bt);
`ifdef ALU_OVF_FLAG_EN
    check("ovf", {63'd0, ovf}, {63'd0, m_ovf});
`endif
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] pick_operand();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 130));
      default: return rand64();
    endcase
  endfunction

  initial begin
    logic [63:0] x, y;
    rst = 1'b1; in_valid = 1'b0; alu_sel = 3'd0;
    a = 64'd0; b = 64'd0; pc = 64'd0; imm = 64'd0;

    step(1'b1, 1'b1, 3'd0, 64'd1, 64'd1, 64'd4, 64'd4);
    step(1'b1, 1'b0, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0);
    check("reset_alu_out", alu_out, 64'd0);

    step(1'b0, 1'b1, 3'd0, 64'd5, 64'd7, 64'h100, 64'd8);
    check("add_5_7", alu_out, 64'd12);
    check("add_zero", {63'd0, zero}, 64'd0);
    check("pc4_0x100", pc_plus4, 64'h104);
    check("bt_0x100", branch_target, 64'h110);

    step(1'b0, 1'b1, 3'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);
    check("sub_3_5", alu_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("pc4_wrap", pc_plus4, 64'd0);

    step(1'b0, 1'b1, 3'd1, 64'd9, 64'd9, 64'd0, 64'd0);
    check("sub_9_9_zero", {63'd0, zero}, 64'd1);

    step(1'b0, 1'b1, 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
    check("slt_m1_1", alu_out, 64'd1);

    step(1'b0, 1'b1, 3'd5, 64'd1, 64'h43, 64'd0, 64'd0);
    check("sll_1_0x43", alu_out, 64'd8);

    step(1'b0, 1'b1, 3'd6, 64'h8000_0000_0000_0000, 64'hFFC0, 64'd0, 64'd0);
    check("srl_shamt0", alu_out, 64'h8000_0000_0000_0000);

    step(1'b0, 1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0);
    check("add_ovf_val", alu_out, 64'h8000_0000_0000_0000);
`ifdef ALU_OVF_FLAG_EN
    check("add_ovf_flag", {63'd0, ovf}, 64'd1);
`endif

    // Reset in the middle of back-to-back valid ops, then idle cycles.
    step(1'b0, 1'b1, 3'd4, 64'hF0F0, 64'h0FF0, 64'h2000, 64'd3);
    step(1'b1, 1'b1, 3'd3, 64'h1234, 64'h5678, 64'h3000, 64'd5);
    check("rst_mid_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_alu", alu_out, 64'd0);
    step(1'b0, 1'b0, 3'd0, 64'd77, 64'd1, 64'h40, 64'd1);
    step(1'b0, 1'b0, 3'd2, 64'd55, 64'd1, 64'h80, 64'd2);
    check("idle_hold_alu", alu_out, 64'd0);
    check("idle_hold_bt", branch_target, 64'd0);

    for (int i = 0; i < 300; i++) begin
      x = pick_operand();
      y = pick_operand();
      step(1'b0, ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
           x, y, rand64(), rand64());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
